// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette RAM geometry defaults and clear-sequencer states.
package ppu_pkg;

  localparam int PAL_ADDR_W = 8;
  localparam int PAL_DATA_W = 15;

  typedef enum logic {
    PAL_IDLE,
    PAL_CLEAR
  } pal_state_t;

endpackage

// File: rtl/ppu_palram_dpb.sv
// True dual-port palette array, read-first on both ports, registered read data.
// Behavioural model; FPGA builds substitute the vendor dual-port block RAM.
module ppu_palram_dpb
  import ppu_pkg::*;
#(
  parameter int ADDR_W = PAL_ADDR_W,
  parameter int DATA_W = PAL_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Output registers sample the pre-write contents, giving read-first collisions.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= mem[a_addr];
      if (b_re) b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/ppu_palram.sv
// Palette RAM: byte-serial CPU port with auto-increment, pipelined render port,
// and a clear sequencer that zero-fills the array through port B.
module ppu_palram
  import ppu_pkg::*;
#(
  parameter int ADDR_W = PAL_ADDR_W,
  parameter int DATA_W = PAL_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_addr_wr,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic              cpu_data_wr,
  input  logic [7:0]        cpu_data_in,
  input  logic              cpu_data_rd,
  output logic [7:0]        cpu_data_out,
  output logic [ADDR_W-1:0] cpu_addr_out,
  input  logic              render_en,
  input  logic [ADDR_W-1:0] render_addr,
  output logic [DATA_W-1:0] render_q,
  output logic              render_valid,
  input  logic              clr_req,
  output logic              clr_busy
);

  pal_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              busy;

  logic [ADDR_W-1:0] cpu_addr;
  logic              flip;
  logic [7:0]        latch;
  logic              wr_stb, rd_stb, a_we;
  logic [DATA_W-1:0] a_wdata, a_q, b_q;
  logic [7:0]        rd_hi, rd_byte;

  logic [ADDR_W-1:0] b_addr;
  logic              v1, z1;
  logic [DATA_W-1:0] q1;

  logic              unused_din;
  assign unused_din = ^cpu_data_in;

  // Clear sequencer
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PAL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == PAL_CLEAR) cnt <= cnt + 1'b1;
      else                    cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PAL_IDLE:  if (clr_req) state_nxt = PAL_CLEAR;
      PAL_CLEAR: if (cnt == '1) state_nxt = PAL_IDLE;
      default:   state_nxt = PAL_IDLE;
    endcase
  end

  assign busy     = (state == PAL_CLEAR);
  assign clr_busy = busy;

  // CPU port: address load beats write, write beats read
  always_comb begin
    wr_stb  = cpu_data_wr & ~cpu_addr_wr;
    rd_stb  = cpu_data_rd & ~cpu_addr_wr & ~cpu_data_wr;
    a_we    = wr_stb & flip & ~busy;
    a_wdata = {cpu_data_in[DATA_W-9:0], latch};
    rd_hi   = '0;
    rd_hi[DATA_W-9:0] = a_q[DATA_W-1:8];
    rd_byte = flip ? rd_hi : a_q[7:0];
    if (busy) rd_byte = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_addr     <= '0;
      flip         <= 1'b0;
      latch        <= '0;
      cpu_data_out <= '0;
    end else if (cpu_addr_wr) begin
      cpu_addr <= cpu_addr_in;
      flip     <= 1'b0;
    end else if (wr_stb) begin
      flip <= ~flip;
      if (!flip) latch    <= cpu_data_in;
      else       cpu_addr <= cpu_addr + 1'b1;
    end else if (rd_stb) begin
      cpu_data_out <= rd_byte;
      flip         <= ~flip;
      if (flip) cpu_addr <= cpu_addr + 1'b1;
    end
  end

  assign cpu_addr_out = cpu_addr;

  // Port B carries the clear writes; render data issued while busy is masked.
  assign b_addr = busy ? cnt : render_addr;

  ppu_palram_dpb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dpb (
    .clock   (clock),
    .reset   (reset),
    .a_addr  (cpu_addr),
    .a_we    (a_we),
    .a_wdata (a_wdata),
    .a_q     (a_q),
    .b_addr  (b_addr),
    .b_re    (render_en),
    .b_we    (busy),
    .b_wdata ('0),
    .b_q     (b_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      v1 <= 1'b0;
      z1 <= 1'b0;
    end else begin
      v1 <= render_en;
      if (render_en) z1 <= busy;
    end
  end

  assign q1 = z1 ? '0 : b_q;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2;
      logic [DATA_W-1:0] q2;
      always_ff @(posedge clock) begin
        if (reset) begin
          v2 <= 1'b0;
          q2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) q2 <= q1;
        end
      end
      assign render_q     = q2;
      assign render_valid = v2;
    end else begin : g_lat1
      assign render_q     = q1;
      assign render_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_ppu_palram.sv
// Self-checking bench for ppu_palram: vector table for CPU/render traffic,
// hand sequences for collision and clear/reset corner cases.
module tb_ppu_palram;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 15;
  localparam int RD_LAT = 1;

  logic              clock;
  logic              reset;
  logic              cpu_addr_wr;
  logic [ADDR_W-1:0] cpu_addr_in;
  logic              cpu_data_wr;
  logic [7:0]        cpu_data_in;
  logic              cpu_data_rd;
  logic [7:0]        cpu_data_out;
  logic [ADDR_W-1:0] cpu_addr_out;
  logic              render_en;
  logic [ADDR_W-1:0] render_addr;
  logic [DATA_W-1:0] render_q;
  logic              render_valid;
  logic              clr_req;
  logic              clr_busy;

  ppu_palram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr_wr  (cpu_addr_wr),
    .cpu_addr_in  (cpu_addr_in),
    .cpu_data_wr  (cpu_data_wr),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_rd  (cpu_data_rd),
    .cpu_data_out (cpu_data_out),
    .cpu_addr_out (cpu_addr_out),
    .render_en    (render_en),
    .render_addr  (render_addr),
    .render_q     (render_q),
    .render_valid (render_valid),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy)
  );

  typedef enum {OP_LOAD, OP_WR, OP_RD, OP_REN, OP_ADDR} op_t;
  typedef struct {
    op_t op;
    int  arg;
    int  exp;
  } vec_t;
  typedef struct {
    int data;
    int cyc;
  } rexp_t;

  vec_t  vecs[$];
  rexp_t sb[$];
  rexp_t e;
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    n;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Render scoreboard: each valid beat must match the oldest outstanding request.
  always @(negedge clock) begin
    if (render_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL render_extra actual=valid q=%0h required=no valid", render_q);
      end else begin
        e = sb.pop_front();
        chk("render_q", 32'(render_q), e.data);
        chk("render_lat", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a);
    cpu_addr_in = a[ADDR_W-1:0];
    cpu_addr_wr = 1'b1;
    tick();
    cpu_addr_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr(input int b);
    cpu_data_in = b[7:0];
    cpu_data_wr = 1'b1;
    tick();
    cpu_data_wr = 1'b0;
  endtask

  task automatic rd(input int exp);
    cpu_data_rd = 1'b1;
    tick();
    cpu_data_rd = 1'b0;
    chk("cpu_data_out", 32'(cpu_data_out), exp);
    tick();
    tick();
  endtask

  task automatic push_render(input int exp);
    rexp_t r;
    r.data = exp;
    r.cyc  = cyc + RD_LAT;
    sb.push_back(r);
  endtask

  task automatic ren(input int a, input int exp);
    render_addr = a[ADDR_W-1:0];
    render_en   = 1'b1;
    push_render(exp);
    tick();
    render_en = 1'b0;
  endtask

  function automatic vec_t v(input op_t o, input int a, input int x);
    vec_t r;
    r.op  = o;
    r.arg = a;
    r.exp = x;
    return r;
  endfunction

  initial begin
    reset = 1'b1; cpu_addr_wr = 0; cpu_addr_in = '0; cpu_data_wr = 0; cpu_data_in = '0;
    cpu_data_rd = 0; render_en = 0; render_addr = '0; clr_req = 0;

    // word write, read-back, stale latch, wrap, high-bit truncation
    vecs.push_back(v(OP_LOAD, 'h10, 0));  vecs.push_back(v(OP_WR, 'h1F, 0));
    vecs.push_back(v(OP_WR, 'h7C, 0));    vecs.push_back(v(OP_ADDR, 0, 'h11));
    vecs.push_back(v(OP_REN, 'h10, 'h7C1F));
    vecs.push_back(v(OP_LOAD, 'h10, 0));  vecs.push_back(v(OP_RD, 0, 'h1F));
    vecs.push_back(v(OP_RD, 0, 'h7C));    vecs.push_back(v(OP_ADDR, 0, 'h11));
    vecs.push_back(v(OP_WR, 'hAA, 0));    vecs.push_back(v(OP_LOAD, 'h20, 0));
    vecs.push_back(v(OP_WR, 'h34, 0));    vecs.push_back(v(OP_WR, 'h12, 0));
    vecs.push_back(v(OP_REN, 'h20, 'h1234));
    vecs.push_back(v(OP_LOAD, 'h20, 0));  vecs.push_back(v(OP_RD, 0, 'h34));
    vecs.push_back(v(OP_RD, 0, 'h12));
    vecs.push_back(v(OP_LOAD, 'hFF, 0));  vecs.push_back(v(OP_WR, 'h55, 0));
    vecs.push_back(v(OP_WR, 'h22, 0));    vecs.push_back(v(OP_ADDR, 0, 'h00));
    vecs.push_back(v(OP_REN, 'hFF, 'h2255));
    vecs.push_back(v(OP_LOAD, 'hFF, 0));  vecs.push_back(v(OP_RD, 0, 'h55));
    vecs.push_back(v(OP_RD, 0, 'h22));    vecs.push_back(v(OP_ADDR, 0, 'h00));
    vecs.push_back(v(OP_LOAD, 'h30, 0));  vecs.push_back(v(OP_WR, 'h00, 0));
    vecs.push_back(v(OP_WR, 'hFF, 0));    vecs.push_back(v(OP_LOAD, 'h30, 0));
    vecs.push_back(v(OP_RD, 0, 'h00));    vecs.push_back(v(OP_RD, 0, 'h7F));
    vecs.push_back(v(OP_REN, 'h30, 'h7F00));
    vecs.push_back(v(OP_LOAD, 'h05, 0));  vecs.push_back(v(OP_WR, 'hFF, 0));
    vecs.push_back(v(OP_WR, 'h7F, 0));    vecs.push_back(v(OP_REN, 'h05, 'h7FFF));

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_cpu_data_out", 32'(cpu_data_out), 0);
    chk("rst_cpu_addr_out", 32'(cpu_addr_out), 0);
    chk("rst_render_q", 32'(render_q), 0);
    chk("rst_render_valid", 32'(render_valid), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_LOAD: load(vecs[i].arg);
        OP_WR:   wr(vecs[i].arg);
        OP_RD:   rd(vecs[i].exp);
        OP_REN:  ren(vecs[i].arg, vecs[i].exp);
        OP_ADDR: chk("cpu_addr_out", 32'(cpu_addr_out), vecs[i].exp);
        default: ;
      endcase
    end

    // Collision: CPU commits 0x0001 to addr 5 while render reads addr 5
    load('h05);
    wr('h01);
    cpu_data_in = 8'h00;
    cpu_data_wr = 1'b1;
    render_addr = 8'h05;
    render_en   = 1'b1;
    push_render('h7FFF);
    tick();
    cpu_data_wr = 1'b0;
    render_en   = 1'b0;
    ren('h05, 'h0001);
    repeat (3) tick();

    // Full clear sweep with a retrigger, a masked render and a masked CPU read
    load('h10);
    rd('h1F);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 400) begin
      n++;
      if (n == 50) clr_req = 1'b1;
      if (n == 51) clr_req = 1'b0;
      if (n == 60) begin
        render_addr = 8'h10;
        render_en   = 1'b1;
        push_render(0);
      end
      if (n == 61) render_en = 1'b0;
      if (n == 80) cpu_data_rd = 1'b1;
      if (n == 81) begin
        cpu_data_rd = 1'b0;
        chk("clr_cpu_read", 32'(cpu_data_out), 0);
      end
      tick();
    end
    clr_req = 1'b0; render_en = 1'b0; cpu_data_rd = 1'b0;
    chk("clr_len", n, 256);
    for (int i = 0; i < 256; i++) begin
      render_addr = i[ADDR_W-1:0];
      render_en   = 1'b1;
      push_render(0);
      tick();
    end
    render_en = 1'b0;
    repeat (3) tick();

    // Reset at cycle 100 of a second sweep aborts it and spares addr 200
    load(200);
    wr('h57);
    wr('h13);
    load('h10);
    wr('h1F);
    wr('h7C);
    load('h10);
    rd('h1F);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (99) tick();
    chk("clr_busy_mid", 32'(clr_busy), 1);
    reset = 1'b1;
    tick();
    chk("abort_clr_busy", 32'(clr_busy), 0);
    chk("abort_cpu_addr", 32'(cpu_addr_out), 0);
    chk("abort_cpu_data", 32'(cpu_data_out), 0);
    reset = 1'b0;
    tick();
    ren(200, 'h1357);
    ren(50, 0);
    load(200);
    rd('h57);
    rd('h13);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
